// File: rtl/baccarat_fsm.sv
// Baccarat dealing controller: a Moore FSM that sequences the card-load strobes
// for one baccarat hand, applies the player/banker third-card rules, and latches
// the win lights.
//
// Ports:
//   slow_clock        sole clock, rising edge
//   resetb            synchronous active-high reset
//   pscore, dscore    current player/dealer hand scores (0..9), from the card datapath
//   pcard3            player third card code (0 = none, 1..13 = A..K)
//   load_pcard1..3    single-cycle load strobes for the player card registers
//   load_dcard1..3    single-cycle load strobes for the dealer card registers
//   player_win_light  registered result light (both lights high = tie)
//   dealer_win_light  registered result light
module baccarat_fsm (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       player_win_light,
   output logic       dealer_win_light
);

   typedef enum logic [3:0] {
      StDealP1  = 4'd0,
      StDealD1  = 4'd1,
      StDealP2  = 4'd2,
      StDealD2  = 4'd3,
      StCheck   = 4'd4,
      StDealP3  = 4'd5,
      StBank    = 4'd6,
      StDealD3  = 4'd7,
      StResult  = 4'd8,
      StDone    = 4'd9
   } state_e;

   state_e     state_q, state_d;
   logic       player_q, player_d;
   logic       dealer_q, dealer_d;
   logic [3:0] third_val;
   logic       bank_draw;

   always_ff @(posedge slow_clock) begin
      if (resetb) begin
         state_q  <= StDealP1;
         player_q <= 1'b0;
         dealer_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         dealer_q <= dealer_d;
      end
   end

   // Banker third-card chart; face cards and tens count as zero.
   always_comb begin
      third_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
      bank_draw = 1'b0;
      case (dscore)
         4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
         4'd3:             bank_draw = (third_val != 4'd8);
         4'd4:             bank_draw = (third_val >= 4'd2) && (third_val <= 4'd7);
         4'd5:             bank_draw = (third_val >= 4'd4) && (third_val <= 4'd7);
         4'd6:             bank_draw = (third_val >= 4'd6) && (third_val <= 4'd7);
         default:          bank_draw = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      player_d    = player_q;
      dealer_d    = dealer_q;
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_dcard1 = 1'b0;
      load_dcard2 = 1'b0;
      load_dcard3 = 1'b0;
      case (state_q)
         StDealP1: begin
            load_pcard1 = 1'b1;
            state_d     = StDealD1;
         end
         StDealD1: begin
            load_dcard1 = 1'b1;
            state_d     = StDealP2;
         end
         StDealP2: begin
            load_pcard2 = 1'b1;
            state_d     = StDealD2;
         end
         StDealD2: begin
            load_dcard2 = 1'b1;
            state_d     = StCheck;
         end
         StCheck: begin
            if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
               state_d = StResult;
            end else if (pscore <= 4'd5) begin
               state_d = StDealP3;
            end else if (dscore <= 4'd5) begin
               // Player stood on 6/7; dealer draws on 0..5.
               state_d = StDealD3;
            end else begin
               state_d = StResult;
            end
         end
         StDealP3: begin
            load_pcard3 = 1'b1;
            state_d     = StBank;
         end
         StBank: begin
            state_d = bank_draw ? StDealD3 : StResult;
         end
         StDealD3: begin
            load_dcard3 = 1'b1;
            state_d     = StResult;
         end
         StResult: begin
            // Equal scores set both lights to signal a tie.
            player_d = (pscore >= dscore);
            dealer_d = (dscore >= pscore);
            state_d  = StDone;
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StDealP1;
         end
      endcase
      // Reset must silence the strobes even before the state register is cleared.
      if (resetb) begin
         load_pcard1 = 1'b0;
         load_pcard2 = 1'b0;
         load_pcard3 = 1'b0;
         load_dcard1 = 1'b0;
         load_dcard2 = 1'b0;
         load_dcard3 = 1'b0;
      end
   end

   assign player_win_light = player_q;
   assign dealer_win_light = dealer_q;

endmodule

// File: tb/tb_baccarat_fsm.sv
// Bench for baccarat_fsm: a card datapath driven by the DUT strobes, a game-level
// reference model, and one per-cycle compare process.
module tb_baccarat_fsm;

   logic       slow_clock;
   logic       resetb;
   logic [3:0] pscore, dscore, pcard3;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic       player_win_light, dealer_win_light;

   baccarat_fsm dut (
      .slow_clock       (slow_clock),
      .resetb           (resetb),
      .pscore           (pscore),
      .dscore           (dscore),
      .pcard3           (pcard3),
      .load_pcard1      (load_pcard1),
      .load_pcard2      (load_pcard2),
      .load_pcard3      (load_pcard3),
      .load_dcard1      (load_dcard1),
      .load_dcard2      (load_dcard2),
      .load_dcard3      (load_dcard3),
      .player_win_light (player_win_light),
      .dealer_win_light (dealer_win_light)
   );

   initial slow_clock = 1'b0;
   always #5 slow_clock = ~slow_clock;

   // Strobe vector order: P1 D1 P2 D2 P3 D3
   localparam logic [5:0] SP1 = 6'b100000;
   localparam logic [5:0] SD1 = 6'b010000;
   localparam logic [5:0] SP2 = 6'b001000;
   localparam logic [5:0] SD2 = 6'b000100;
   localparam logic [5:0] SP3 = 6'b000010;
   localparam logic [5:0] SD3 = 6'b000001;

   int tests = 0;
   int fails = 0;

   // Deck: player1, dealer1, player2, dealer2, player3, dealer3
   logic [3:0] deck [6];
   logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;

   function automatic int card_val(input logic [3:0] c);
      return (c >= 4'd10) ? 0 : int'(c);
   endfunction

   // Card datapath around the FSM
   always @(posedge slow_clock) begin
      if (resetb) begin
         pc1 <= 4'd0; pc2 <= 4'd0; pc3 <= 4'd0;
         dc1 <= 4'd0; dc2 <= 4'd0; dc3 <= 4'd0;
      end else begin
         if (load_pcard1) pc1 <= deck[0];
         if (load_dcard1) dc1 <= deck[1];
         if (load_pcard2) pc2 <= deck[2];
         if (load_dcard2) dc2 <= deck[3];
         if (load_pcard3) pc3 <= deck[4];
         if (load_dcard3) dc3 <= deck[5];
      end
   end
   assign pscore = 4'((card_val(pc1) + card_val(pc2) + card_val(pc3)) % 10);
   assign dscore = 4'((card_val(dc1) + card_val(dc2) + card_val(dc3)) % 10);
   assign pcard3 = pc3;

   // Reference model of one hand
   logic [5:0] exp_strobe [64];
   int         done_cyc;
   logic [1:0] final_l;

   function automatic bit banker_draws(input int ds, input int v);
      case (ds)
         0, 1, 2: return 1'b1;
         3:       return v != 8;
         4:       return v inside {[2:7]};
         5:       return v inside {[4:7]};
         6:       return v inside {[6:7]};
         default: return 1'b0;
      endcase
   endfunction

   task automatic build_model();
      int v [6];
      int ps, ds, c;
      bit pdraw, ddraw;
      for (int i = 0; i < 6; i++) v[i] = card_val(deck[i]);
      for (int i = 0; i < 64; i++) exp_strobe[i] = 6'b0;
      exp_strobe[0] = SP1; exp_strobe[1] = SD1;
      exp_strobe[2] = SP2; exp_strobe[3] = SD2;
      ps = (v[0] + v[2]) % 10;
      ds = (v[1] + v[3]) % 10;
      pdraw = 1'b0; ddraw = 1'b0;
      if (ps >= 8 || ds >= 8) begin
         pdraw = 1'b0;
      end else if (ps <= 5) begin
         pdraw = 1'b1;
         ddraw = banker_draws(ds, v[4]);
      end else begin
         ddraw = (ds <= 5);
      end
      c = 5;  // first cycle after the check cycle
      if (pdraw) begin
         exp_strobe[c] = SP3;
         c = c + 2;  // third card, then the banker decision cycle
         ps = (ps + v[4]) % 10;
      end
      if (ddraw) begin
         exp_strobe[c] = SD3;
         c = c + 1;
         ds = (ds + v[5]) % 10;
      end
      done_cyc = c + 1;
      final_l  = {ps >= ds, ds >= ps};
   endtask

   // Literal checks are posted here and evaluated by the compare process.
   string lit_name [64];
   int    lit_act  [64];
   int    lit_exp  [64];
   int    lit_n = 0;
   int    lit_k = 0;

   task automatic post(input string name, input int act, input int exp);
      lit_name[lit_n] = name;
      lit_act[lit_n]  = act;
      lit_exp[lit_n]  = exp;
      lit_n = lit_n + 1;
   endtask

   // Cycle index since the last reset edge
   int cyc = 0;
   bit rst_seen = 1'b0;
   always @(posedge slow_clock) begin
      if (resetb) begin
         cyc      <= 0;
         rst_seen <= 1'b1;
      end else begin
         cyc      <= cyc + 1;
         rst_seen <= 1'b0;
      end
   end

   bit         run_en = 1'b0;
   logic [5:0] strb, exp_s;
   logic [1:0] act_l, exp_l;

   always @(negedge slow_clock) begin
      while (lit_k < lit_n) begin
         tests = tests + 1;
         if (lit_act[lit_k] != lit_exp[lit_k]) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, required %0d", lit_name[lit_k], lit_act[lit_k],
                     lit_exp[lit_k]);
         end
         lit_k = lit_k + 1;
      end
      if (run_en) begin
         strb  = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
         act_l = {player_win_light, dealer_win_light};
         tests = tests + 1;
         if ($countones(strb) > 1) begin
            fails = fails + 1;
            $display("FAIL one_strobe: strobes=%b, required at most one high", strb);
         end
         if (resetb) exp_s = 6'b0;
         else        exp_s = (cyc < 64) ? exp_strobe[cyc] : 6'b0;
         tests = tests + 1;
         if (strb !== exp_s) begin
            fails = fails + 1;
            $display("FAIL strobes cyc=%0d rst=%b: got %b, required %b", cyc, resetb, strb, exp_s);
         end
         // Lights are only defined once a reset edge has landed or during a game.
         if (!resetb || rst_seen) begin
            exp_l = (!resetb && cyc >= done_cyc) ? final_l : 2'b00;
            tests = tests + 1;
            if (act_l !== exp_l) begin
               fails = fails + 1;
               $display("FAIL lights cyc=%0d rst=%b: got %b, required %b", cyc, resetb, act_l,
                        exp_l);
            end
         end
      end
   end

   // Runs one hand from reset; pin = also check literal expectations.
   task automatic play(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] d3, input logic [3:0] d4, input logic [3:0] d5,
                       input int hold, input bit pin, input string name,
                       input int exp_done, input logic [1:0] exp_lights);
      resetb  = 1'b1;
      deck[0] = d0; deck[1] = d1; deck[2] = d2;
      deck[3] = d3; deck[4] = d4; deck[5] = d5;
      build_model();
      if (pin) begin
         post({name, "_model_done"}, done_cyc, exp_done);
         post({name, "_model_lights"}, int'(final_l), int'(exp_lights));
      end
      repeat (2) @(posedge slow_clock);
      #1 resetb = 1'b0;
      repeat (done_cyc + hold) @(posedge slow_clock);
      #1;
      if (pin) post({name, "_dut_lights"}, int'({player_win_light, dealer_win_light}),
                    int'(exp_lights));
   endtask

   initial begin
      resetb = 1'b1;
      for (int i = 0; i < 6; i++) deck[i] = 4'd0;
      build_model();
      repeat (2) @(posedge slow_clock);
      #1 run_en = 1'b1;

      // Natural 8 vs 3: player wins, done at cycle 6
      play(4'd3, 4'd1, 4'd5, 4'd2, 4'd9, 4'd9, 3, 1'b1, "natural", 6, 2'b10);
      // Player 6 stands, dealer 4 draws a 3 -> 7: dealer wins
      play(4'd2, 4'd1, 4'd4, 4'd3, 4'd1, 4'd3, 3, 1'b1, "dealer_draw", 7, 2'b01);
      // Player 2 draws 8 -> 0, dealer 3 stands on v=8
      play(4'd1, 4'd1, 4'd1, 4'd2, 4'd8, 4'd5, 3, 1'b1, "bank_3_v8", 8, 2'b01);
      // Player draws queen (v=0), dealer 3 draws 4 -> 7
      play(4'd1, 4'd1, 4'd1, 4'd2, 4'd12, 4'd4, 3, 1'b1, "bank_3_q", 9, 2'b01);
      // Player draws 6 -> 8, dealer 6 draws king -> 6
      play(4'd1, 4'd3, 4'd1, 4'd3, 4'd6, 4'd13, 3, 1'b1, "bank_6_v6", 9, 2'b10);
      // Tie at 5 held for 25 cycles
      play(4'd2, 4'd2, 4'd3, 4'd3, 4'd10, 4'd7, 25, 1'b1, "tie", 8, 2'b11);

      // Reset while the player third card is being dealt
      resetb  = 1'b1;
      deck[0] = 4'd1; deck[1] = 4'd1; deck[2] = 4'd1;
      deck[3] = 4'd2; deck[4] = 4'd8; deck[5] = 4'd5;
      build_model();
      repeat (2) @(posedge slow_clock);
      #1 resetb = 1'b0;
      repeat (5) @(posedge slow_clock);
      #1;
      post("midreset_in_p3", int'(load_pcard3), 1);
      resetb = 1'b1;
      repeat (2) @(posedge slow_clock);
      #1;
      play(4'd3, 4'd1, 4'd5, 4'd2, 4'd9, 4'd9, 2, 1'b1, "after_reset", 6, 2'b10);

      for (int g = 0; g < 40; g++) begin
         play(4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
              4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
              int'($urandom_range(1, 4)), 1'b0, "rand", 0, 2'b00);
      end

      resetb = 1'b1;
      repeat (3) @(negedge slow_clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/baccarat_fsm.md
BACCARAT_FSM -- requirements
Module: baccarat_fsm

Interface
REQ-001 Parameters: none.
REQ-002 slow_clock  in  1  sole clock; every state and output register SHALL update on its rising edge.
REQ-003 resetb  in  1  reset, synchronous and active-high; sampled only on the slow_clock rising edge.
REQ-004 pscore  in  4  player hand score, 0..9, valid one cycle after any player load.
REQ-005 dscore  in  4  dealer hand score, 0..9, valid one cycle after any dealer load.
REQ-006 pcard3  in  4  player third card code: 0 = none, 1..13 = A..K.
REQ-007 load_pcard1, load_pcard2, load_pcard3  out  1 each  single-cycle load strobes to the player card registers.
REQ-008 load_dcard1, load_dcard2, load_dcard3  out  1 each  single-cycle load strobes to the dealer card registers.
REQ-009 player_win_light, dealer_win_light  out  1 each  registered result lights; both high = tie.

Function
REQ-010 Outputs SHALL be produced by a Moore FSM with states DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK, DEAL_P3, BANK, DEAL_D3, RESULT, DONE.
REQ-011 At most one load strobe SHALL be high in any cycle; a strobe SHALL be high only in its own deal state, for exactly one cycle.
REQ-012 Fixed sequence: DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> CHECK, one cycle each, unconditional.
REQ-013 CHECK: pscore >= 8 or dscore >= 8 -> RESULT (natural).
REQ-014 CHECK, no natural, pscore <= 5 -> DEAL_P3.
REQ-015 CHECK, no natural, pscore 6 or 7: dscore <= 5 -> DEAL_D3; otherwise -> RESULT.
REQ-016 DEAL_P3 -> BANK unconditionally.
REQ-017 BANK SHALL compute third-card value v = 0 when pcard3 >= 10, else v = pcard3.
REQ-018 BANK SHALL go to DEAL_D3 when any of the following holds, otherwise to RESULT:
- dscore <= 2
- dscore = 3 and v != 8
- dscore = 4 and v in 2..7
- dscore = 5 and v in 4..7
- dscore = 6 and v in 6..7
REQ-019 BANK with dscore >= 7 SHALL always go to RESULT.
REQ-020 DEAL_D3 -> RESULT unconditionally.
REQ-021 RESULT: on the edge leaving RESULT, lights SHALL load as follows:
- pscore > dscore -> player = 1, dealer = 0
- dscore > pscore -> player = 0, dealer = 1
- equal -> both 1
REQ-022 RESULT -> DONE; DONE SHALL self-loop with all strobes low and lights held until reset.
REQ-023 Scores SHALL be compared as 4-bit unsigned values; inputs above 9 are not range-checked.
REQ-024 Latency from reset release: the 2-card natural path reaches DONE at cycle 6, the longest path (player and dealer third cards) at cycle 9, where cycle 0 is the first cycle in DEAL_P1.
REQ-025 Lights SHALL never change in any state other than on the RESULT -> DONE edge.

Reset
REQ-026 resetb = 1 at a rising edge SHALL force state DEAL_P1 and clear both lights, overriding every transition, in any state including mid-deal.
REQ-027 While resetb is high, all load strobes SHALL be 0 (reset overrides state decode).
REQ-028 On the first edge with resetb = 0, the FSM SHALL be in DEAL_P1 with load_pcard1 = 1.
REQ-029 No state other than DEAL_P1 SHALL be reachable directly from reset; unused encodings SHALL return to DEAL_P1 on the next edge.

Verification
REQ-030 Natural: pscore = 8, dscore = 3 at CHECK -> strobes P1, D1, P2, D2 only; at DONE player = 1, dealer = 0.
REQ-031 Player stands, dealer draws: pscore = 6, dscore = 4 at CHECK -> load_dcard3 one cycle, no load_pcard3; final dscore = 7 -> dealer = 1.
REQ-032 BANK table corners:
- pscore = 2, pcard3 = 8 (v = 8), dscore = 3 -> no dealer third card.
- pcard3 = 12 (v = 0), dscore = 3 -> load_dcard3 asserted.
- pcard3 = 6, dscore = 6 -> load_dcard3 asserted.
REQ-033 Tie: final pscore = dscore = 5 -> both lights 1 in DONE, held 20+ cycles.
REQ-034 Reset mid-operation: assert resetb during DEAL_P3 -> next cycle strobes 0 and lights 0; after release, load_pcard1 is the first strobe.
REQ-035 Every run: a checker SHALL flag any cycle with two or more strobes high.
